// File: rtl/vend_change_ctrl.sv
// Coin-accepting vending controller: collects N/D/Q credit in nickel units,
// vends at a programmable price and pays change/refunds one coin per cycle.
module vend_change_ctrl #(
  parameter int PRICE_N      = 5,
  parameter int MAX_CREDIT_N = 20,
  parameter int CREDIT_W     = 5,
  parameter int COUNT_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_n,
  input  logic                coin_d,
  input  logic                coin_q,
  input  logic                cancel,
  output logic                dispense,
  output logic                ret_nickel,
  output logic                ret_dime,
  output logic                ret_quarter,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [COUNT_W-1:0]  sales_count
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_N);
  localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE_N);
  localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W+1)'(MAX_CREDIT_N);
  localparam logic [CREDIT_W-1:0] Q_VAL   = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] D_VAL   = CREDIT_W'(2);
  localparam logic [CREDIT_W-1:0] N_VAL   = CREDIT_W'(1);

  state_t                state, state_next;
  logic [CREDIT_W-1:0]   credit_next;
  logic                  sales_inc;
  logic                  reject_next;
  logic                  coin_any;
  logic                  coin_multi;
  logic [CREDIT_W-1:0]   coin_val;
  logic [CREDIT_W:0]     coin_sum;
  logic [CREDIT_W-1:0]   change_val;

  assign coin_any   = coin_n | coin_d | coin_q;
  assign coin_multi = (coin_n & coin_d) | (coin_n & coin_q) | (coin_d & coin_q);
  assign coin_val   = coin_q ? Q_VAL : (coin_d ? D_VAL : (coin_n ? N_VAL : '0));
  // One extra bit so an over-ceiling sum is detected instead of wrapping.
  assign coin_sum   = {1'b0, credit} + {1'b0, coin_val};

  // Greedy change: largest coin not exceeding the remaining credit.
  assign change_val = (credit >= Q_VAL) ? Q_VAL :
                      (credit >= D_VAL) ? D_VAL : N_VAL;

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    credit_next = credit;
    sales_inc   = 1'b0;
    reject_next = 1'b0;
    unique case (state)
      COLLECT: begin
        if (cancel) begin
          reject_next = coin_any;
          if (credit != '0) state_next = CHANGE;
        end else if (coin_multi || (coin_any && (coin_sum > MAX_X))) begin
          reject_next = 1'b1;
        end else if (coin_any) begin
          credit_next = coin_sum[CREDIT_W-1:0];
          if (coin_sum >= PRICE_X) state_next = VEND;
        end
      end
      VEND: begin
        reject_next = coin_any;
        sales_inc   = 1'b1;
        credit_next = credit - PRICE_C;
        state_next  = (credit != PRICE_C) ? CHANGE : COLLECT;
      end
      CHANGE: begin
        reject_next = coin_any;
        credit_next = credit - change_val;
        if (credit == change_val) state_next = COLLECT;
      end
      default: begin
        state_next  = COLLECT;
        credit_next = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= COLLECT;
      credit      <= '0;
      sales_count <= '0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_next;
      credit      <= credit_next;
      coin_reject <= reject_next;
      if (sales_inc) sales_count <= sales_count + 1'b1;
    end
  end

  assign dispense    = (state == VEND);
  assign busy        = (state != COLLECT);
  assign ret_quarter = (state == CHANGE) && (change_val == Q_VAL);
  assign ret_dime    = (state == CHANGE) && (change_val == D_VAL);
  assign ret_nickel  = (state == CHANGE) && (change_val == N_VAL);

endmodule

// File: tb/tb_vend_change_ctrl.sv
// Scoreboard bench for vend_change_ctrl: expected per-cycle output snapshots
// are queued with the stimulus and compared by a negedge monitor.
module tb_vend_change_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_n = 1'b0, coin_d = 1'b0, coin_q = 1'b0, cancel = 1'b0;
  logic       dispense, ret_nickel, ret_dime, ret_quarter, coin_reject, busy;
  logic [4:0] credit;
  logic [7:0] sales_count;

  vend_change_ctrl dut (
    .clk(clk), .reset(reset),
    .coin_n(coin_n), .coin_d(coin_d), .coin_q(coin_q), .cancel(cancel),
    .dispense(dispense), .ret_nickel(ret_nickel), .ret_dime(ret_dime),
    .ret_quarter(ret_quarter), .coin_reject(coin_reject), .busy(busy),
    .credit(credit), .sales_count(sales_count)
  );

  always #5 clk = ~clk;

  // Flag vector order: {dispense, ret_nickel, ret_dime, ret_quarter, coin_reject, busy}
  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_DISP = 6'b100000;
  localparam logic [5:0] F_RN   = 6'b010000;
  localparam logic [5:0] F_RD   = 6'b001000;
  localparam logic [5:0] F_REJ  = 6'b000010;
  localparam logic [5:0] F_BUSY = 6'b000001;

  typedef struct {
    int         due;
    string      tag;
    logic [5:0] flags;
    logic [4:0] credit;
    logic [7:0] sales;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] flags_now();
    return {dispense, ret_nickel, ret_dime, ret_quarter, coin_reject, busy};
  endfunction

  // Expected snapshot after `off` more rising edges.
  task automatic expect_out(input int off, input string tag, input logic [5:0] flags,
                            input int cr, input int sales);
    exp_t e;
    e.due    = cyc + off;
    e.tag    = tag;
    e.flags  = flags;
    e.credit = 5'(cr);
    e.sales  = 8'(sales);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due < cyc) check({e.tag, "_missed"}, 32'(cyc), 32'(e.due));
      check({e.tag, "_flags"}, 32'(flags_now()), 32'(e.flags));
      check({e.tag, "_credit"}, 32'(credit), 32'(e.credit));
      check({e.tag, "_sales"}, 32'(sales_count), 32'(e.sales));
    end
  end

  task automatic apply(input logic n, input logic d, input logic q, input logic c);
    coin_n = n; coin_d = d; coin_q = q; cancel = c;
    @(posedge clk);
    #1;
    coin_n = 1'b0; coin_d = 1'b0; coin_q = 1'b0; cancel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("reset_flags", 32'(flags_now()), 32'(F_NONE));
    check("reset_credit", 32'(credit), 32'd0);
    check("reset_sales", 32'(sales_count), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // 1: quarter at zero credit vends exactly, no change.
    expect_out(1, "t1_vend", F_DISP | F_BUSY, 5, 0);
    expect_out(2, "t1_done", F_NONE, 0, 1);
    apply(0, 0, 1, 0);
    idle(2);

    // 2: three dimes -> vend, one nickel change.
    expect_out(1, "t2_d1", F_NONE, 2, 1);
    apply(0, 1, 0, 0);
    expect_out(1, "t2_d2", F_NONE, 4, 1);
    apply(0, 1, 0, 0);
    expect_out(1, "t2_vend", F_DISP | F_BUSY, 6, 1);
    expect_out(2, "t2_rn", F_RN | F_BUSY, 1, 2);
    expect_out(3, "t2_done", F_NONE, 0, 2);
    apply(0, 1, 0, 0);
    idle(3);

    // 3: D,D,Q -> credit 9, vend, two dimes change.
    expect_out(1, "t3_d1", F_NONE, 2, 2);
    apply(0, 1, 0, 0);
    expect_out(1, "t3_d2", F_NONE, 4, 2);
    apply(0, 1, 0, 0);
    expect_out(1, "t3_vend", F_DISP | F_BUSY, 9, 2);
    expect_out(2, "t3_rd1", F_RD | F_BUSY, 4, 3);
    expect_out(3, "t3_rd2", F_RD | F_BUSY, 2, 3);
    expect_out(4, "t3_done", F_NONE, 0, 3);
    apply(0, 0, 1, 0);
    idle(4);

    // 4: N,D then cancel -> refund dime + nickel, no vend.
    expect_out(1, "t4_n", F_NONE, 1, 3);
    apply(1, 0, 0, 0);
    expect_out(1, "t4_d", F_NONE, 3, 3);
    apply(0, 1, 0, 0);
    expect_out(1, "t4_rd", F_RD | F_BUSY, 3, 3);
    expect_out(2, "t4_rn", F_RN | F_BUSY, 1, 3);
    expect_out(3, "t4_done", F_NONE, 0, 3);
    apply(0, 0, 0, 1);
    idle(3);

    // 5: two coins at once rejected; quarter during VEND rejected.
    expect_out(1, "t5_multi", F_REJ, 0, 3);
    expect_out(2, "t5_clear", F_NONE, 0, 3);
    apply(1, 1, 0, 0);
    idle(1);
    expect_out(1, "t5_vend", F_DISP | F_BUSY, 5, 3);
    apply(0, 0, 1, 0);
    expect_out(1, "t5_vrej", F_REJ, 0, 4);
    expect_out(2, "t5_vclr", F_NONE, 0, 4);
    apply(0, 0, 1, 0);
    idle(1);

    // Cancel at zero credit ignored; cancel+coin: refund wins, coin rejected.
    expect_out(1, "t5_cancel0", F_NONE, 0, 4);
    apply(0, 0, 0, 1);
    expect_out(1, "t5_n", F_NONE, 1, 4);
    apply(1, 0, 0, 0);
    expect_out(1, "t5_cxl_rej", F_RN | F_REJ | F_BUSY, 1, 4);
    expect_out(2, "t5_cxl_done", F_NONE, 0, 4);
    apply(1, 0, 0, 1);
    idle(2);

    // 6: asynchronous reset in the middle of a refund.
    expect_out(1, "t6_n", F_NONE, 1, 4);
    apply(1, 0, 0, 0);
    expect_out(1, "t6_d", F_NONE, 3, 4);
    apply(0, 1, 0, 0);
    expect_out(1, "t6_chg", F_RD | F_BUSY, 3, 4);
    apply(0, 0, 0, 1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_flags", 32'(flags_now()), 32'(F_NONE));
    check("t6_rst_credit", 32'(credit), 32'd0);
    check("t6_rst_sales", 32'(sales_count), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    expect_out(1, "t6_vend", F_DISP | F_BUSY, 5, 0);
    expect_out(2, "t6_done", F_NONE, 0, 1);
    apply(0, 0, 1, 0);
    idle(3);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
